// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: FSM state
// encoding, default geometry widths and a saturating increment helper.
package icache_pkg;

   localparam int DEF_LINE_WORDS = 4;
   localparam int DEF_NUM_LINES  = 16;
   localparam int DEF_ADDR_W     = 32;

   localparam int OFF_W = $clog2(DEF_LINE_WORDS);
   localparam int IDX_W = $clog2(DEF_NUM_LINES);
   localparam int TAG_W = DEF_ADDR_W - IDX_W - OFF_W - 2;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOOKUP = 3'd1,
      S_REQ    = 3'd2,
      S_REFILL = 3'd3,
      S_RESP   = 3'd4
   } state_e;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/icache_dm_array.sv
// Flop-based tag/valid/data storage for icache_dm: one combinational read
// port, one word write port with a tag/valid write on the last beat, clear-all.
module icache_dm_array #(
   parameter int IDX_BITS = 4,
   parameter int OFF_BITS = 2,
   parameter int TAG_BITS = 26
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                inv_all,
   input  logic [IDX_BITS-1:0] rd_idx,
   input  logic [OFF_BITS-1:0] rd_off,
   output logic                rd_valid,
   output logic [TAG_BITS-1:0] rd_tag,
   output logic [31:0]         rd_word,
   input  logic                wr_en,
   input  logic [IDX_BITS-1:0] wr_idx,
   input  logic [OFF_BITS-1:0] wr_off,
   input  logic [31:0]         wr_data,
   input  logic                tag_we,
   input  logic [TAG_BITS-1:0] tag_wdata
);

   localparam int NUM_LINES  = 1 << IDX_BITS;
   localparam int LINE_WORDS = 1 << OFF_BITS;

   logic [NUM_LINES-1:0] valid_q, valid_d;
   logic [TAG_BITS-1:0]  tag_q  [NUM_LINES];
   logic [TAG_BITS-1:0]  tag_d  [NUM_LINES];
   logic [31:0]          data_q [NUM_LINES][LINE_WORDS];
   logic [31:0]          data_d [NUM_LINES][LINE_WORDS];

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      data_d  = data_q;
      if (inv_all) begin
         valid_d = '0;
      end
      if (wr_en) begin
         data_d[wr_idx][wr_off] = wr_data;
      end
      // The line only becomes visible once its last word is in place.
      if (tag_we) begin
         valid_d[wr_idx] = 1'b1;
         tag_d[wr_idx]   = tag_wdata;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q <= '0;
         tag_q   <= '{default: '0};
      end else begin
         valid_q <= valid_d;
         tag_q   <= tag_d;
      end
   end

   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign rd_valid = valid_q[rd_idx];
   assign rd_tag   = tag_q[rd_idx];
   assign rd_word  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache with whole-line refill and fetch
// cancel. Optional hit/miss counters are enabled by defining ICACHE_PERF_CNT_EN.
module icache_dm
   import icache_pkg::*;
#(
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int NUM_LINES  = DEF_NUM_LINES,
   parameter int ADDR_W     = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_cancel,
   output logic              cpu_ready,
   output logic              cpu_inst_valid,
   output logic [31:0]       cpu_inst,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   input  logic              inv_all,
`ifdef ICACHE_PERF_CNT_EN
   output logic [31:0]       hit_cnt,
   output logic [31:0]       miss_cnt,
`endif
   output state_e            dbg_state
);

   localparam int OFF_BITS = $clog2(LINE_WORDS);
   localparam int IDX_BITS = $clog2(NUM_LINES);
   localparam int TAG_BITS = ADDR_W - IDX_BITS - OFF_BITS - 2;
   localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(LINE_WORDS - 1);

   // Handshake: a fetch is accepted on a clock edge where cpu_req & cpu_ready;
   // mem_req is held with a stable mem_addr until the edge where mem_ack is high.
   state_e              state_q, state_d;
   logic [ADDR_W-3:0]   addr_q, addr_d;
   logic [OFF_BITS-1:0] beat_q, beat_d;
   logic                cancel_pend_q, cancel_pend_d;
   logic                inst_valid_q, inst_valid_d;
   logic [31:0]         inst_q, inst_d;
   logic                mem_req_q, mem_req_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;

   logic [OFF_BITS-1:0] cur_off;
   logic [IDX_BITS-1:0] cur_idx;
   logic [TAG_BITS-1:0] cur_tag;
   logic                arr_rd_valid;
   logic [TAG_BITS-1:0] arr_rd_tag;
   logic [31:0]         arr_rd_word;
   logic                arr_wr_en, arr_tag_we, arr_inv;
   logic                lookup_hit;
   logic                hit_evt, miss_evt;
   logic                unused_addr_bits;

   assign unused_addr_bits = ^cpu_addr[1:0];

   assign cur_off = addr_q[0 +: OFF_BITS];
   assign cur_idx = addr_q[OFF_BITS +: IDX_BITS];
   assign cur_tag = addr_q[ADDR_W-3 -: TAG_BITS];

   icache_dm_array #(
      .IDX_BITS (IDX_BITS),
      .OFF_BITS (OFF_BITS),
      .TAG_BITS (TAG_BITS)
   ) u_array (
      .clk       (clk),
      .reset     (reset),
      .inv_all   (arr_inv),
      .rd_idx    (cur_idx),
      .rd_off    (cur_off),
      .rd_valid  (arr_rd_valid),
      .rd_tag    (arr_rd_tag),
      .rd_word   (arr_rd_word),
      .wr_en     (arr_wr_en),
      .wr_idx    (cur_idx),
      .wr_off    (beat_q),
      .wr_data   (mem_rdata),
      .tag_we    (arr_tag_we),
      .tag_wdata (cur_tag)
   );

   assign lookup_hit = arr_rd_valid && (arr_rd_tag == cur_tag);

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      beat_d        = beat_q;
      cancel_pend_d = cancel_pend_q;
      inst_valid_d  = 1'b0;
      inst_d        = inst_q;
      mem_req_d     = mem_req_q;
      mem_addr_d    = mem_addr_q;
      arr_wr_en     = 1'b0;
      arr_tag_we    = 1'b0;
      arr_inv       = 1'b0;
      cpu_ready     = 1'b0;
      hit_evt       = 1'b0;
      miss_evt      = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Invalidate and cancel both block acceptance in the same cycle.
            cpu_ready = !inv_all && !cpu_cancel;
            if (inv_all) begin
               arr_inv = 1'b1;
            end else if (cpu_req && cpu_ready) begin
               addr_d  = cpu_addr[ADDR_W-1:2];
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            hit_evt  = lookup_hit;
            miss_evt = !lookup_hit;
            if (cpu_cancel) begin
               state_d = S_IDLE;
            end else if (lookup_hit) begin
               inst_valid_d = 1'b1;
               inst_d       = arr_rd_word;
               state_d      = S_IDLE;
            end else begin
               mem_req_d     = 1'b1;
               mem_addr_d    = {cur_tag, cur_idx, {(OFF_BITS + 2){1'b0}}};
               cancel_pend_d = 1'b0;
               state_d       = S_REQ;
            end
         end
         S_REQ: begin
            if (cpu_cancel) cancel_pend_d = 1'b1;
            if (mem_ack) begin
               mem_req_d = 1'b0;
               beat_d    = '0;
               state_d   = S_REFILL;
            end
         end
         S_REFILL: begin
            // A cancel here still lets the fill finish; only the response is dropped.
            if (cpu_cancel) cancel_pend_d = 1'b1;
            if (mem_rvalid) begin
               arr_wr_en = 1'b1;
               beat_d    = beat_q + 1'b1;
               if (beat_q == LAST_BEAT) begin
                  arr_tag_we = 1'b1;
                  state_d    = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (!cancel_pend_q && !cpu_cancel) begin
               inst_valid_d = 1'b1;
               inst_d       = arr_rd_word;
            end
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         addr_q        <= '0;
         beat_q        <= '0;
         cancel_pend_q <= 1'b0;
         inst_valid_q  <= 1'b0;
         inst_q        <= '0;
         mem_req_q     <= 1'b0;
         mem_addr_q    <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         beat_q        <= beat_d;
         cancel_pend_q <= cancel_pend_d;
         inst_valid_q  <= inst_valid_d;
         inst_q        <= inst_d;
         mem_req_q     <= mem_req_d;
         mem_addr_q    <= mem_addr_d;
      end
   end

   assign cpu_inst_valid = inst_valid_q;
   assign cpu_inst       = inst_q;
   assign mem_req        = mem_req_q;
   assign mem_addr       = mem_addr_q;
   assign dbg_state      = state_q;

`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt_q, hit_cnt_d;
   logic [31:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_evt  ? sat_inc(hit_cnt_q)  : hit_cnt_q;
      miss_cnt_d = miss_evt ? sat_inc(miss_cnt_q) : miss_cnt_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
`else
   logic unused_perf;
   assign unused_perf = hit_evt ^ miss_evt;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Directed self-checking bench for icache_dm: cold miss, hit, conflict,
// cancel, invalidate-all and asynchronous reset during a refill.
module tb_icache_dm;
   import icache_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic        cpu_cancel = 1'b0;
   logic        cpu_ready;
   logic        cpu_inst_valid;
   logic [31:0] cpu_inst;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ack = 1'b0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        inv_all = 1'b0;
   state_e      dbg_state;
`ifdef ICACHE_PERF_CNT_EN
   logic [31:0] hit_cnt, miss_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int pulse_cnt = 0;

   icache_dm dut (
      .clk            (clk),
      .reset          (reset),
      .cpu_req        (cpu_req),
      .cpu_addr       (cpu_addr),
      .cpu_cancel     (cpu_cancel),
      .cpu_ready      (cpu_ready),
      .cpu_inst_valid (cpu_inst_valid),
      .cpu_inst       (cpu_inst),
      .mem_req        (mem_req),
      .mem_addr       (mem_addr),
      .mem_ack        (mem_ack),
      .mem_rvalid     (mem_rvalid),
      .mem_rdata      (mem_rdata),
      .inv_all        (inv_all),
`ifdef ICACHE_PERF_CNT_EN
      .hit_cnt        (hit_cnt),
      .miss_cnt       (miss_cnt),
`endif
      .dbg_state      (dbg_state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (cpu_inst_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] a);
      cpu_addr = a;
      cpu_req  = 1'b1;
      tick();
      cpu_req  = 1'b0;
   endtask

   // Acks after ack_wait cycles (a stray rvalid in the first wait cycle),
   // then streams LINE_WORDS beats base+i; cpu_cancel is raised on beat cancel_beat.
   task automatic refill(input logic [31:0] base, input int ack_wait, input int cancel_beat);
      for (int w = 0; w < ack_wait; w++) begin
         mem_rvalid = (w == 0);
         mem_rdata  = 32'hDEAD_BEEF;
         tick();
      end
      mem_rvalid = 1'b0;
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      for (int i = 0; i < 4; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = base + 32'(i);
         cpu_cancel = (i == cancel_beat);
         tick();
      end
      mem_rvalid = 1'b0;
      cpu_cancel = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_tests++;
      if (cpu_inst_valid !== 1'b0 || cpu_inst !== 32'h0 || mem_req !== 1'b0 || mem_addr !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: valid=%b inst=%h mem_req=%b mem_addr=%h, required 0/0/0/0",
                  cpu_inst_valid, cpu_inst, mem_req, mem_addr);
      end
      n_tests++;
      if (dbg_state !== S_IDLE || cpu_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: state=%0d ready=%b, required 0/1", dbg_state, cpu_ready);
      end
      tick();
      reset = 1'b0;
      tick();
   endtask

   task automatic test_cold_miss();
      int p0;
      issue(32'h10);
      tick();
      n_tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
         n_fail++;
         $display("FAIL cold_miss_req: mem_req=%b mem_addr=%h, required 1/00000010", mem_req, mem_addr);
      end
      p0 = pulse_cnt;
      refill(32'hA0, 2, -1);
      n_tests++;
      if (mem_req !== 1'b0 || cpu_inst_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL cold_miss_after_fill: mem_req=%b valid=%b, required 0/0", mem_req, cpu_inst_valid);
      end
      tick();
      n_tests++;
      if (cpu_inst_valid !== 1'b1 || cpu_inst !== 32'hA0) begin
         n_fail++;
         $display("FAIL cold_miss_resp: valid=%b inst=%h, required 1/000000a0", cpu_inst_valid, cpu_inst);
      end
      tick();
      n_tests++;
      if (cpu_inst_valid !== 1'b0 || cpu_inst !== 32'hA0 || pulse_cnt !== p0 + 1) begin
         n_fail++;
         $display("FAIL cold_miss_pulse: valid=%b inst=%h pulses=%0d, required 0/000000a0/%0d",
                  cpu_inst_valid, cpu_inst, pulse_cnt - p0, 1);
      end
   endtask

   task automatic test_hit();
      issue(32'h18);
      tick();
      n_tests++;
      if (cpu_inst_valid !== 1'b1 || cpu_inst !== 32'hA2 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL hit_resp: valid=%b inst=%h mem_req=%b, required 1/000000a2/0",
                  cpu_inst_valid, cpu_inst, mem_req);
      end
      tick();
      n_tests++;
      if (cpu_inst_valid !== 1'b0 || dbg_state !== S_IDLE) begin
         n_fail++;
         $display("FAIL hit_pulse_end: valid=%b state=%0d, required 0/0", cpu_inst_valid, dbg_state);
      end
`ifdef ICACHE_PERF_CNT_EN
      n_tests++;
      if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin
         n_fail++;
         $display("FAIL perf_cnt: hit=%0d miss=%0d, required 1/1", hit_cnt, miss_cnt);
      end
`endif
   endtask

   task automatic test_conflict();
      issue(32'h110);
      tick();
      n_tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h110) begin
         n_fail++;
         $display("FAIL conflict_req: mem_req=%b mem_addr=%h, required 1/00000110", mem_req, mem_addr);
      end
      refill(32'hB0, 1, -1);
      tick();
      n_tests++;
      if (cpu_inst_valid !== 1'b1 || cpu_inst !== 32'hB0) begin
         n_fail++;
         $display("FAIL conflict_resp: valid=%b inst=%h, required 1/000000b0", cpu_inst_valid, cpu_inst);
      end
      tick();
      issue(32'h10);
      tick();
      n_tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
         n_fail++;
         $display("FAIL conflict_evicted: mem_req=%b mem_addr=%h, required 1/00000010", mem_req, mem_addr);
      end
      refill(32'hA0, 0, -1);
      tick();
      n_tests++;
      if (cpu_inst_valid !== 1'b1 || cpu_inst !== 32'hA0) begin
         n_fail++;
         $display("FAIL conflict_refetch: valid=%b inst=%h, required 1/000000a0", cpu_inst_valid, cpu_inst);
      end
      tick();
   endtask

   task automatic test_cancel();
      int p0;
      issue(32'h200);
      tick();
      n_tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
         n_fail++;
         $display("FAIL cancel_req: mem_req=%b mem_addr=%h, required 1/00000200", mem_req, mem_addr);
      end
      p0 = pulse_cnt;
      refill(32'hD0, 1, 2);
      tick();
      tick();
      tick();
      n_tests++;
      if (pulse_cnt !== p0 || dbg_state !== S_IDLE || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL cancel_refill: pulses=%0d state=%0d mem_req=%b, required 0/0/0",
                  pulse_cnt - p0, dbg_state, mem_req);
      end
      issue(32'h204);
      tick();
      n_tests++;
      if (cpu_inst_valid !== 1'b1 || cpu_inst !== 32'hD1 || mem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL cancel_followup_hit: valid=%b inst=%h mem_req=%b, required 1/000000d1/0",
                  cpu_inst_valid, cpu_inst, mem_req);
      end
      tick();
      // Cancel together with a request in IDLE: not accepted.
      cpu_cancel = 1'b1;
      cpu_req    = 1'b1;
      cpu_addr   = 32'h204;
      #1;
      n_tests++;
      if (cpu_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL cancel_idle_ready: ready=%b, required 0", cpu_ready);
      end
      tick();
      cpu_cancel = 1'b0;
      cpu_req    = 1'b0;
      n_tests++;
      if (dbg_state !== S_IDLE) begin
         n_fail++;
         $display("FAIL cancel_idle_state: state=%0d, required 0", dbg_state);
      end
      // Cancel during the LOOKUP of a hit: no response.
      p0 = pulse_cnt;
      issue(32'h204);
      cpu_cancel = 1'b1;
      tick();
      cpu_cancel = 1'b0;
      tick();
      n_tests++;
      if (pulse_cnt !== p0 || dbg_state !== S_IDLE) begin
         n_fail++;
         $display("FAIL cancel_lookup: pulses=%0d state=%0d, required 0/0", pulse_cnt - p0, dbg_state);
      end
   endtask

   task automatic test_inv_all();
      cpu_req  = 1'b1;
      cpu_addr = 32'h18;
      inv_all  = 1'b1;
      #1;
      n_tests++;
      if (cpu_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL inv_ready: ready=%b, required 0", cpu_ready);
      end
      tick();
      cpu_req = 1'b0;
      inv_all = 1'b0;
      tick();
      n_tests++;
      if (dbg_state !== S_IDLE || mem_req !== 1'b0 || cpu_inst_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL inv_not_accepted: state=%0d mem_req=%b valid=%b, required 0/0/0",
                  dbg_state, mem_req, cpu_inst_valid);
      end
      issue(32'h18);
      tick();
      n_tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
         n_fail++;
         $display("FAIL inv_miss: mem_req=%b mem_addr=%h, required 1/00000010", mem_req, mem_addr);
      end
      refill(32'hA0, 0, -1);
      tick();
      n_tests++;
      if (cpu_inst_valid !== 1'b1 || cpu_inst !== 32'hA2) begin
         n_fail++;
         $display("FAIL inv_refill_resp: valid=%b inst=%h, required 1/000000a2", cpu_inst_valid, cpu_inst);
      end
      tick();
      issue(32'h204);
      tick();
      n_tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h200) begin
         n_fail++;
         $display("FAIL inv_other_line: mem_req=%b mem_addr=%h, required 1/00000200", mem_req, mem_addr);
      end
      refill(32'hD0, 0, -1);
      tick();
      n_tests++;
      if (cpu_inst_valid !== 1'b1 || cpu_inst !== 32'hD1) begin
         n_fail++;
         $display("FAIL inv_other_resp: valid=%b inst=%h, required 1/000000d1", cpu_inst_valid, cpu_inst);
      end
      tick();
   endtask

   task automatic test_reset_mid_refill();
      issue(32'h300);
      tick();
      n_tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
         n_fail++;
         $display("FAIL rst_mid_req: mem_req=%b mem_addr=%h, required 1/00000300", mem_req, mem_addr);
      end
      mem_ack = 1'b1;
      tick();
      mem_ack = 1'b0;
      for (int i = 0; i < 2; i++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = 32'hE0 + 32'(i);
         tick();
      end
      mem_rvalid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      n_tests++;
      if (cpu_inst_valid !== 1'b0 || cpu_inst !== 32'h0 || mem_req !== 1'b0 ||
          mem_addr !== 32'h0 || dbg_state !== S_IDLE) begin
         n_fail++;
         $display("FAIL rst_mid_outputs: valid=%b inst=%h mem_req=%b mem_addr=%h state=%0d, required 0/0/0/0/0",
                  cpu_inst_valid, cpu_inst, mem_req, mem_addr, dbg_state);
      end
      reset = 1'b0;
      tick();
      issue(32'h300);
      tick();
      n_tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h300) begin
         n_fail++;
         $display("FAIL rst_mid_remiss: mem_req=%b mem_addr=%h, required 1/00000300", mem_req, mem_addr);
      end
      refill(32'hF0, 0, -1);
      tick();
      n_tests++;
      if (cpu_inst_valid !== 1'b1 || cpu_inst !== 32'hF0) begin
         n_fail++;
         $display("FAIL rst_mid_refill_resp: valid=%b inst=%h, required 1/000000f0", cpu_inst_valid, cpu_inst);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_hit();
      test_conflict();
      test_cancel();
      test_inv_all();
      test_reset_mid_refill();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
